// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer.
// The cell state encoding is fixed so that bit 1 of the state doubles as the
// "currently accepted high" flag (HIGH and FALL_CHK both report level 1).
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } cell_state_t;

    // Default tick counts for the 10 kHz system tick.
    localparam int DEB_TICKS_20MS   = 200;
    localparam int REP_DELAY_500MS  = 5000;
    localparam int REP_PERIOD_100MS = 1000;

    // Larger of two integers, used to size the shared repeat counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_debouncer_cell.sv
// debounce_cell: one input bit through a 2-flop synchroniser and a
// four-state debounce FSM. Produces a level and registered one-cycle
// rise/fall pulses that assert in the same cycle the level changes.
// With INPUT_DEBOUNCER_REPEAT_EN defined, cells built with REPEAT_EN=1
// emit extra rise pulses while the input is held high.
module debounce_cell
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEB_TICKS_20MS,
    parameter int REPEAT_DELAY   = REP_DELAY_500MS,
    parameter int REPEAT_PERIOD  = REP_PERIOD_100MS,
    parameter bit REPEAT_EN      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync_q;
    logic             in_s;
    cell_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_accept, fall_accept;
    logic             rep_fire;
    logic             rise_q, fall_q;

    // Two-flop synchroniser; the FSM only ever looks at the second stage.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign in_s = sync_q[1];

    // Debounce state, stability counter and registered edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_accept | rep_fire;
            fall_q  <= fall_accept;
        end
    end

    // Next-state logic: a candidate level must be seen DEBOUNCE_TICKS
    // consecutive synchronised cycles; any reversal drops back silently.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rise_accept = 1'b0;
        fall_accept = 1'b0;
        unique case (state_q)
            LOW: begin
                if (in_s) begin
                    if (DEBOUNCE_TICKS == 1) begin
                        state_d     = HIGH;
                        cnt_d       = '0;
                        rise_accept = 1'b1;
                    end else begin
                        state_d = RISE_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RISE_CHK: begin
                if (!in_s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HIGH;
                    cnt_d       = '0;
                    rise_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!in_s) begin
                    if (DEBOUNCE_TICKS == 1) begin
                        state_d     = LOW;
                        cnt_d       = '0;
                        fall_accept = 1'b1;
                    end else begin
                        state_d = FALL_CHK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            FALL_CHK: begin
                if (in_s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = LOW;
                    cnt_d       = '0;
                    fall_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef INPUT_DEBOUNCER_REPEAT_EN
    localparam int               REP_W         = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [REP_W-1:0] REP_ONE       = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DEL_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PER_LAST  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;

    // Repeat counter: cycles since the last press pulse while staying HIGH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end

    // First repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD;
    // anything other than remaining in HIGH clears the sequence.
    always_comb begin
        rep_d       = '0;
        rep_first_d = 1'b0;
        rep_fire    = 1'b0;
        if (REPEAT_EN && state_q == HIGH && state_d == HIGH) begin
            if (rep_q == (rep_first_q ? REP_PER_LAST : REP_DEL_LAST)) begin
                rep_fire    = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_d       = rep_q + REP_ONE;
                rep_first_d = rep_first_q;
            end
        end
    end
`else
    // Repeat feature compiled out: parameters are accepted but carry no logic.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD + int'(REPEAT_EN);
    assign rep_fire = 1'b0;
`endif

    assign level      = (state_q == HIGH) || (state_q == FALL_CHK);
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: conditions raw slide-switch and push-button samples from
// the board I/O stage. Every bit is synchronised and debounced
// independently; buttons also produce one-cycle press/release pulses.
// Optional auto-repeat on buttons: define INPUT_DEBOUNCER_REPEAT_EN.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEB_TICKS_20MS,
    parameter int REPEAT_DELAY   = REP_DELAY_500MS,
    parameter int REPEAT_PERIOD  = REP_PERIOD_100MS
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] User_Input0,
    input  logic [3:0] User_Input1,
    output logic [3:0] Switch_Level,
    output logic [3:0] Button_Level,
    output logic [3:0] Button_Press,
    output logic [3:0] Button_Release,
    output logic       Any_Press
);

    // Switch cells share the FSM but their edge pulses have no consumer.
    logic [3:0] unused_switch_rise;
    logic [3:0] unused_switch_fall;

    for (genvar i = 0; i < 4; i++) begin : g_switch
        debounce_cell #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (1'b0)
        ) u_cell (
            .clk        (CLK),
            .rst        (RST),
            .raw        (User_Input0[i]),
            .level      (Switch_Level[i]),
            .rise_pulse (unused_switch_rise[i]),
            .fall_pulse (unused_switch_fall[i])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_button
        debounce_cell #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (1'b1)
        ) u_cell (
            .clk        (CLK),
            .rst        (RST),
            .raw        (User_Input1[i]),
            .level      (Button_Level[i]),
            .rise_pulse (Button_Press[i]),
            .fall_pulse (Button_Release[i])
        );
    end

    // Press pulses are already registered, so the OR adds no latency.
    assign Any_Press = |Button_Press;

endmodule
